display_7seg_scanner: RTL and testbench
=======================================

# display_7seg_scanner

- Parametrised time-multiplexed 7-segment display driver.
- Drives `DIGITS` common-anode digits from one shared segment bus by rotating the active anode at a prescaled refresh rate.
- A double-buffered load path keeps display updates atomic at frame boundaries.
- Sits between any value-producing datapath and the board's display pins; it replaces fixed, always-on anode selection.

## Interface

Parameters:
- `DIGITS`, default 4: number of digits. Legal range 1..8.
- `PRESCALE`, default 50000: clocks per digit slot. Must be ≥1.

Ports:
- `CLK`, input, 1: system clock; all state changes on its rising edge.
- `RST`, input, 1: asynchronous, active-high reset.
- `DATA`, input, 4*DIGITS: hex nibble per digit; nibble i (`DATA[4i+3:4i]`) is digit i, and digit 0 is rightmost.
- `DP`, input, DIGITS: decimal point request per digit, active-high.
- `EN_DIG`, input, DIGITS: digit enable mask, active-high.
- `LOAD`, input, 1: capture `DATA`/`DP`/`EN_DIG` into the pending buffer.
- `BUSY`, output, 1: pending buffer holds data not yet displayed.
- `SEG`, output, 7: `{g,f,e,d,c,b,a}`, active-low.
- `DPO`, output, 1: decimal point segment, active-low.
- `AC`, output, DIGITS: anode controls, active-low; at most one bit is low at any time.
- `FRAME`, output, 1: one-clock pulse on each wrap to digit 0.

## Operation

State:
- Prescale counter `pcnt`, width clog2(PRESCALE), max 1 bit.
- Slot index `idx`, width clog2(DIGITS), max 1 bit.
- Pending registers `{DATA,DP,EN_DIG}` plus flag `pend`.
- Active registers `{DATA,DP,EN_DIG}`.

Prescale and slot index:
- `tick` = (`pcnt` == PRESCALE-1).
- On `tick`, `pcnt` returns to 0; otherwise it increments.
- On `tick`, `idx` advances: DIGITS-1 wraps to 0, else +1.
- Frame boundary = `tick` while `idx` == DIGITS-1.

Load path:
- `LOAD` high on an edge writes `DATA`/`DP`/`EN_DIG` into pending and sets `pend`.
- A later `LOAD` before the boundary overwrites pending; last write wins.
- At a frame boundary with `pend`=1, pending is copied into active.
- At a frame boundary with `pend`=1, `pend` clears, unless `LOAD` is high on that same edge. In that case the old pending contents move to active, the new input goes to pending, and `pend` stays 1.
- `BUSY` = `pend`.

Outputs, registered and updated only on `tick` for the new `idx`:
- If the digit is shown: `AC` = ~(1<<idx); `SEG` = decode(active nibble idx); `DPO` = ~active DP[idx].
- If the digit is not shown: `AC` all 1, `SEG`=7'h7F, `DPO`=1.
- A digit is shown when active `EN_DIG[idx]`=1 and it is not suppressed (see Configuration).
- The decode uses active data that already includes any copy made on the same boundary edge.
- `FRAME` = 1 for the single clock after a boundary edge, otherwise 0.

Hex decode (SEG hex values):
- 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
- 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E

## Timing

- Reset values:
  - `pcnt`=0; `idx`=DIGITS-1.
  - Pending, active and `pend` all 0.
  - `AC` all 1, `SEG`=7'h7F, `DPO`=1, `FRAME`=0, `BUSY`=0.
- Reset mid-scan aborts immediately, with no partial frame. Any pending load is discarded.
- Because `idx` resets to DIGITS-1, the first `tick` after reset release is a frame boundary. It occurs on the PRESCALE-th rising edge after release.
- Active data is all 0 after reset, so nothing is displayed until the first load has been transferred.
- `LOAD`-to-display latency:
  - Best case: 1 clock (`LOAD` on the boundary edge with `pend`=0 still waits for the next boundary; the best case is `LOAD` one clock before the boundary).
  - Worst case: DIGITS*PRESCALE clocks.
- `BUSY` rises the clock after `LOAD`. It falls on the boundary edge that performs the transfer.
- DIGITS=1: every tick is a boundary and `AC` stays on digit 0.
- PRESCALE=1: tick every clock.

## Configuration

- Macro: `DISPLAY_7SEG_SCANNER_LZB_EN` (leading-zero blanking).
- Defined:
  - Digit i is suppressed when active nibbles i..DIGITS-1 are all 0 and active DP bits i..DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - Suppression is evaluated from active registers and only affects `AC`/`SEG`/`DPO` for that slot.
- Undefined: no suppression logic is compiled. Every enabled digit is shown, including leading zeros.

## Test plan

All scenarios use DIGITS=4, PRESCALE=4.

1. **Reset, no load:** assert `RST` mid-scan, then release → all outputs hold reset values; `FRAME` pulses after the 4th edge; `AC` stays 4'hF because EN_DIG=0.
2. **Basic load:** `LOAD` with `DATA`=16'h1234, `EN_DIG`=4'hF, `DP`=4'b0010 → `BUSY`=1 until the boundary. In the next frame, slots 0..3 give:
   - `AC`=E,D,B,7
   - `SEG`=19,30,24,79
   - `DPO`=1,0,1,1
3. **Enable mask:** `EN_DIG`=4'b0101 → slots 1 and 3 give `AC`=4'hF, `SEG`=7F; slots 0 and 2 display normally.
4. **Load on boundary edge:** `LOAD` A on one clock, then `LOAD` B on the boundary edge → frame shows A; `BUSY` stays 1; frame after shows B; `BUSY` then falls.
5. **Macro defined:** `DATA`=16'h0050, `EN_DIG`=F → digits 3 and 2 blanked; digit 1 `SEG`=12; digit 0 `SEG`=40. `DATA`=0 → only digit 0 lit. With the macro undefined, all four digits are lit.
6. **Last write wins:** three `LOAD`s (hex 1111, 2222, 3333) within one frame → the next frame shows only 3333; `FRAME` pulses once per 16 clocks.

Source files
------------

// File: rtl/display_7seg_scanner.sv
// Time-multiplexed 7-segment driver: rotates one active-low anode across DIGITS
// common-anode digits and double-buffers loads so updates land on frame boundaries.
// Optional leading-zero blanking is compiled in with `define DISPLAY_7SEG_SCANNER_LZB_EN.
module display_7seg_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   DATA,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     EN_DIG,
  input  logic                  LOAD,
  output logic                  BUSY,
  output logic [6:0]            SEG,
  output logic                  DPO,
  output logic [DIGITS-1:0]     AC,
  output logic                  FRAME
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   en;
  } disp_buf_t;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    hex_decode = 7'h7F;
    case (nib)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      4'hF: hex_decode = 7'h0E;
      default: hex_decode = 7'h7F;
    endcase
  endfunction

  logic [PW-1:0] pcnt;
  logic [IW-1:0] idx;
  disp_buf_t     pending;
  disp_buf_t     active;
  logic          pend;

  logic          tick;
  logic          boundary;
  logic          xfer;
  logic [IW-1:0] idx_nxt;
  disp_buf_t     act_nxt;
  logic [3:0]    nib;
  logic          dp_bit;
  logic          en_bit;
  logic          suppress;
  logic          shown;

  // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
  always_comb begin
    tick     = (pcnt == PCNT_LAST);
    boundary = tick && (idx == IDX_LAST);
    xfer     = boundary && pend;
    idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    // The slot shown right after a boundary must already see the transferred frame.
    act_nxt  = xfer ? pending : active;
    nib      = act_nxt.data[{idx_nxt, 2'b00} +: 4];
    dp_bit   = act_nxt.dp[idx_nxt];
    en_bit   = act_nxt.en[idx_nxt];
    shown    = en_bit && !suppress;
  end

`ifdef DISPLAY_7SEG_SCANNER_LZB_EN
  logic [DIGITS-1:0] lead_zero;

  // Scan from the most significant digit down; a digit blanks while nothing above
  // or at it carries a non-zero nibble or a decimal point. Digit 0 always shows.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    lead_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen         = seen | (act_nxt.data[4*i +: 4] != 4'h0) | act_nxt.dp[i];
      lead_zero[i] = !seen && (i != 0);
    end
  end

  assign suppress = lead_zero[idx_nxt];
`else
  assign suppress = 1'b0;
`endif

  assign BUSY = pend;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcnt    <= '0;
      idx     <= IDX_LAST;
      pending <= '0;
      active  <= '0;
      pend    <= 1'b0;
      AC      <= '1;
      SEG     <= 7'h7F;
      DPO     <= 1'b1;
      FRAME   <= 1'b0;
    end else begin
      pcnt  <= tick ? '0 : pcnt + 1'b1;
      FRAME <= boundary;

      if (tick) begin
        idx <= idx_nxt;
        if (shown) begin
          AC  <= ~(DIGITS'(1) << idx_nxt);
          SEG <= hex_decode(nib);
          DPO <= ~dp_bit;
        end else begin
          AC  <= '1;
          SEG <= 7'h7F;
          DPO <= 1'b1;
        end
      end

      if (xfer)
        active <= pending;

      // A load on the transfer edge refills pending, so pend stays set.
      if (LOAD) begin
        pending <= '{data: DATA, dp: DP, en: EN_DIG};
        pend    <= 1'b1;
      end else if (xfer) begin
        pend    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_7seg_scanner.sv
// Scoreboard bench for display_7seg_scanner (DIGITS=4, PRESCALE=4): a frame-level
// reference model predicts each clock's outputs; a negedge monitor compares them.
module tb_display_7seg_scanner;

  localparam int D = 4;
  localparam int P = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] DATA;
  logic [3:0]  DP;
  logic [3:0]  EN_DIG;
  logic        LOAD;
  logic        BUSY;
  logic [6:0]  SEG;
  logic        DPO;
  logic [3:0]  AC;
  logic        FRAME;

  always #5 CLK = ~CLK;

  display_7seg_scanner #(.DIGITS(D), .PRESCALE(P)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .DP(DP), .EN_DIG(EN_DIG), .LOAD(LOAD),
    .BUSY(BUSY), .SEG(SEG), .DPO(DPO), .AC(AC), .FRAME(FRAME)
  );

  typedef struct packed {
    logic [3:0] ac;
    logic [6:0] seg;
    logic       dpo;
    logic       frame;
    logic       busy;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         checking = 1'b0;
  logic [6:0] hex_tab[16];

  // Reference model: frame buffers plus edge count since reset release.
  int          edge_cnt;
  logic [15:0] m_pdata, m_adata;
  logic [3:0]  m_pdp, m_pen, m_adp, m_aen;
  bit          m_pend;
  exp_t        m_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edge e (1-based after release) is the k-th tick when e = k*P; tick k selects
  // slot (k-1) mod D, and a boundary is a tick that lands on slot 0.
  function automatic bit is_boundary(input int e);
    return (e % P == 0) && ((((e / P) - 1) % D) == 0);
  endfunction

  function automatic bit digit_shown(input int i);
    bit vis;
    vis = m_aen[i];
`ifdef DISPLAY_7SEG_SCANNER_LZB_EN
    if (i != 0 && (m_adata >> (4*i)) == 16'h0 && (m_adp >> i) == 4'h0)
      vis = 1'b0;
`endif
    return vis;
  endfunction

  task automatic model_reset();
    edge_cnt = 0;
    m_pdata = '0; m_pdp = '0; m_pen = '0; m_pend = 1'b0;
    m_adata = '0; m_adp = '0; m_aen = '0;
    m_out = '{ac: 4'hF, seg: 7'h7F, dpo: 1'b1, frame: 1'b0, busy: 1'b0};
  endtask

  // One clock: drive inputs, predict the post-edge outputs, queue them after the edge.
  task automatic cycle(input bit ld, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    bit tick, bnd;
    int slot;
    LOAD = ld; DATA = d; DP = dp; EN_DIG = en;
    edge_cnt++;
    tick = (edge_cnt % P == 0);
    bnd  = is_boundary(edge_cnt);
    if (bnd && m_pend) begin
      m_adata = m_pdata; m_adp = m_pdp; m_aen = m_pen;
    end
    if (ld) begin
      m_pdata = d; m_pdp = dp; m_pen = en; m_pend = 1'b1;
    end else if (bnd) begin
      m_pend = 1'b0;
    end
    if (tick) begin
      slot = ((edge_cnt / P) - 1) % D;
      if (digit_shown(slot)) begin
        m_out.ac  = ~(4'b0001 << slot);
        m_out.seg = hex_tab[m_adata[4*slot +: 4]];
        m_out.dpo = ~m_adp[slot];
      end else begin
        m_out.ac  = 4'hF;
        m_out.seg = 7'h7F;
        m_out.dpo = 1'b1;
      end
    end
    m_out.frame = bnd;
    m_out.busy  = m_pend;
    @(posedge CLK);
    exp_q.push_back(m_out);
    #1;
    LOAD = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_AC"},    AC,    4'hF);
    check({tag, "_SEG"},   SEG,   7'h7F);
    check({tag, "_DPO"},   DPO,   1'b1);
    check({tag, "_FRAME"}, FRAME, 1'b0);
    check({tag, "_BUSY"},  BUSY,  1'b0);
  endtask

  // Called at posedge+1: let the monitor consume the last entry, then reset mid-scan.
  task automatic do_reset();
    #5;
    checking = 1'b0;
    exp_q.delete();
    RST = 1'b1;
    #1;
    check_reset_vals("rst_async");
    @(posedge CLK);
    #1;
    check_reset_vals("rst_held");
    model_reset();
    RST = 1'b0;
    checking = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (checking && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("AC",    AC,    e.ac);
      check("SEG",   SEG,   e.seg);
      check("DPO",   DPO,   e.dpo);
      check("FRAME", FRAME, e.frame);
      check("BUSY",  BUSY,  e.busy);
    end
  end

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    RST = 1'b1; LOAD = 1'b0; DATA = '0; DP = '0; EN_DIG = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_vals("por");
    model_reset();
    RST = 1'b0;
    checking = 1'b1;

    // Reset, no load; then a mid-scan reset with a load in flight.
    idle(6);
    cycle(1'b1, 16'hABCD, 4'hF, 4'hF);
    idle(1);
    do_reset();
    idle(20);

    // Basic load.
    cycle(1'b1, 16'h1234, 4'b0010, 4'hF);
    idle(40);

    // Enable mask.
    cycle(1'b1, 16'h9A5C, 4'b0100, 4'b0101);
    idle(32);

    // Load A just before the boundary, then load B on the boundary edge.
    while (!is_boundary(edge_cnt + 2)) idle(1);
    cycle(1'b1, 16'h5678, 4'b0001, 4'hF);
    cycle(1'b1, 16'hBEEF, 4'b1000, 4'hF);
    idle(40);

    // Leading-zero cases.
    cycle(1'b1, 16'h0050, 4'h0, 4'hF);
    idle(20);
    cycle(1'b1, 16'h0000, 4'h0, 4'hF);
    idle(20);
    cycle(1'b1, 16'h0000, 4'b0100, 4'hF);
    idle(20);

    // Last write wins.
    while (!is_boundary(edge_cnt + 1)) idle(1);
    idle(1);
    cycle(1'b1, 16'h1111, 4'h0, 4'hF);
    idle(2);
    cycle(1'b1, 16'h2222, 4'h0, 4'hF);
    idle(3);
    cycle(1'b1, 16'h3333, 4'h0, 4'hF);
    idle(40);

    // Random traffic, including back-to-back loads.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom), 4'($urandom));

    #5;
    #1;
    check("queue_drained", exp_q.size(), 0);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
